// File: rtl/replica_chain_readout.sv
// replica_chain_readout
// Readout selector for the last node of CHAIN_NUM replica chains. It walks the
// host ordering reads across the chains (ORD_WORDS reads per chain) and steps
// the distance readout one chain per shift. The selected chain's data is
// registered onto the bus-facing outputs.
// Optional feature: define READOUT_ERR_EN to build the sticky rd_err flag
// (read issued while the registered ordering valid is low). When the macro
// is not defined, rd_err is tied low.
module replica_chain_readout #(
  parameter int CHAIN_NUM = 2,
  parameter int ORD_WORDS = 4,
  parameter int ORD_W     = 64,
  parameter int DIS_W     = 32,
  localparam int CH_W     = (CHAIN_NUM > 1) ? $clog2(CHAIN_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_clear,
  input  logic                       ordering_read,
  input  logic [CHAIN_NUM-1:0]       ord_in_valid,
  input  logic [CHAIN_NUM*ORD_W-1:0] ord_in_data,
  output logic                       ordering_out_valid,
  output logic [ORD_W-1:0]           ordering_out_data,
  input  logic                       distance_shift,
  input  logic [CHAIN_NUM*DIS_W-1:0] dis_in_data,
  output logic [DIS_W-1:0]           distance_rdata,
  output logic [CH_W-1:0]            ord_chain,
  output logic [CH_W-1:0]            dis_chain,
  output logic                       ord_wrap,
  output logic                       rd_err
);

  localparam int WD_W = (ORD_WORDS > 1) ? $clog2(ORD_WORDS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHAIN_NUM - 1);
  localparam logic [WD_W-1:0] LAST_WD = WD_W'(ORD_WORDS - 1);

  logic [WD_W-1:0]  ord_word;
  logic             sel_vld_p0;
  logic [ORD_W-1:0] sel_ord_p0;
  logic [DIS_W-1:0] sel_dis_p0;

  // ---- stage p0: pick the current chain's inputs by pointer ----
  // Compare-based select keeps the index inside the populated chains even
  // when CHAIN_NUM is not a power of two.
  always_comb begin
    sel_vld_p0 = 1'b0;
    sel_ord_p0 = '0;
    sel_dis_p0 = '0;
    for (int c = 0; c < CHAIN_NUM; c++) begin
      if (ord_chain == CH_W'(c)) begin
        sel_vld_p0 = ord_in_valid[c];
        sel_ord_p0 = ord_in_data[c*ORD_W +: ORD_W];
      end
      if (dis_chain == CH_W'(c)) begin
        sel_dis_p0 = dis_in_data[c*DIS_W +: DIS_W];
      end
    end
  end

  // Ordering/distance pointers; clear outranks reads and shifts and never wraps.
  always_ff @(posedge clk) begin
    if (reset || rd_clear) begin
      ord_word  <= '0;
      ord_chain <= '0;
      dis_chain <= '0;
      ord_wrap  <= 1'b0;
    end else begin
      ord_wrap <= 1'b0;
      if (ordering_read) begin
        if (ord_word == LAST_WD) begin
          ord_word <= '0;
          if (ord_chain == LAST_CH) begin
            ord_chain <= '0;
            ord_wrap  <= 1'b1;
          end else begin
            ord_chain <= ord_chain + 1'b1;
          end
        end else begin
          ord_word <= ord_word + 1'b1;
        end
      end
      if (distance_shift) begin
        if (dis_chain == LAST_CH) begin
          dis_chain <= '0;
        end else begin
          dis_chain <= dis_chain + 1'b1;
        end
      end
    end
  end

  // ---- stage p1: registered readout of the selected chains ----
  // Output registers sample every cycle (including during rd_clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      ordering_out_valid <= 1'b0;
      ordering_out_data  <= '0;
      distance_rdata     <= '0;
    end else begin
      ordering_out_valid <= sel_vld_p0;
      ordering_out_data  <= sel_ord_p0;
      distance_rdata     <= sel_dis_p0;
    end
  end

`ifdef READOUT_ERR_EN
  // Sticky flag: a read seen while the registered valid is low; clear wins.
  always_ff @(posedge clk) begin
    if (reset || rd_clear) begin
      rd_err <= 1'b0;
    end else if (ordering_read && !ordering_out_valid) begin
      rd_err <= 1'b1;
    end
  end
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_replica_chain_readout.sv
// Testbench for replica_chain_readout: two instances (2 chains x 4 words, and
// 4 chains x 1 word) driven by shared control pulses, checked every cycle
// against a count-based reference model plus literal directed expectations.
module tb_replica_chain_readout;

`ifdef READOUT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int A_CN = 2, A_OW = 4;
  localparam int B_CN = 4, B_OW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, rd_clear, ordering_read, distance_shift;

  logic [63:0] data_a [A_CN];
  logic [31:0] dis_a  [A_CN];
  logic [A_CN-1:0] vld_a;
  logic [15:0] data_b [B_CN];
  logic [15:0] dis_b  [B_CN];
  logic [B_CN-1:0] vld_b;

  logic [A_CN*64-1:0] ord_bus_a;
  logic [A_CN*32-1:0] dis_bus_a;
  logic [B_CN*16-1:0] ord_bus_b;
  logic [B_CN*16-1:0] dis_bus_b;

  always_comb begin
    ord_bus_a = '0;
    dis_bus_a = '0;
    ord_bus_b = '0;
    dis_bus_b = '0;
    for (int c = 0; c < A_CN; c++) begin
      ord_bus_a[c*64 +: 64] = data_a[c];
      dis_bus_a[c*32 +: 32] = dis_a[c];
    end
    for (int c = 0; c < B_CN; c++) begin
      ord_bus_b[c*16 +: 16] = data_b[c];
      dis_bus_b[c*16 +: 16] = dis_b[c];
    end
  end

  logic        ov_a, wrap_a, err_a;
  logic [63:0] od_a;
  logic [31:0] dr_a;
  logic [0:0]  oc_a, dc_a;
  logic        ov_b, wrap_b, err_b;
  logic [15:0] od_b, dr_b;
  logic [1:0]  oc_b, dc_b;

  replica_chain_readout #(.CHAIN_NUM(A_CN), .ORD_WORDS(A_OW), .ORD_W(64), .DIS_W(32)) dut_a (
    .clk(clk), .reset(reset), .rd_clear(rd_clear), .ordering_read(ordering_read),
    .ord_in_valid(vld_a), .ord_in_data(ord_bus_a),
    .ordering_out_valid(ov_a), .ordering_out_data(od_a),
    .distance_shift(distance_shift), .dis_in_data(dis_bus_a), .distance_rdata(dr_a),
    .ord_chain(oc_a), .dis_chain(dc_a), .ord_wrap(wrap_a), .rd_err(err_a)
  );

  replica_chain_readout #(.CHAIN_NUM(B_CN), .ORD_WORDS(B_OW), .ORD_W(16), .DIS_W(16)) dut_b (
    .clk(clk), .reset(reset), .rd_clear(rd_clear), .ordering_read(ordering_read),
    .ord_in_valid(vld_b), .ord_in_data(ord_bus_b),
    .ordering_out_valid(ov_b), .ordering_out_data(od_b),
    .distance_shift(distance_shift), .dis_in_data(dis_bus_b), .distance_rdata(dr_b),
    .ord_chain(oc_b), .dis_chain(dc_b), .ord_wrap(wrap_b), .rd_err(err_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pointers are derived from read/shift counts since the
  // last clear; outputs are last cycle's inputs of the chain those counts name.
  int cnt_r_a, cnt_s_a, cnt_r_b, cnt_s_b;
  logic        ev_a, ew_a, ee_a, ev_b, ew_b, ee_b;
  logic [63:0] ed_a;
  logic [31:0] es_a;
  logic [15:0] ed_b, es_b;
  bit started = 1'b0;

  always @(posedge clk) begin
    int ch, dch;
    started = 1'b1;
    if (reset) begin
      cnt_r_a = 0; cnt_s_a = 0; ev_a = 0; ed_a = 0; es_a = 0; ew_a = 0; ee_a = 0;
      cnt_r_b = 0; cnt_s_b = 0; ev_b = 0; ed_b = 0; es_b = 0; ew_b = 0; ee_b = 0;
    end else begin
      // instance A
      ch  = (cnt_r_a / A_OW) % A_CN;
      dch = cnt_s_a % A_CN;
      if (rd_clear) begin
        cnt_r_a = 0; cnt_s_a = 0; ew_a = 0; ee_a = 0;
      end else begin
        if (ERR_EN && ordering_read && !ev_a) ee_a = 1;
        ew_a = ordering_read && (((cnt_r_a + 1) % (A_OW * A_CN)) == 0);
        cnt_r_a += int'(ordering_read);
        cnt_s_a += int'(distance_shift);
      end
      ev_a = vld_a[ch]; ed_a = data_a[ch]; es_a = dis_a[dch];
      // instance B
      ch  = (cnt_r_b / B_OW) % B_CN;
      dch = cnt_s_b % B_CN;
      if (rd_clear) begin
        cnt_r_b = 0; cnt_s_b = 0; ew_b = 0; ee_b = 0;
      end else begin
        if (ERR_EN && ordering_read && !ev_b) ee_b = 1;
        ew_b = ordering_read && (((cnt_r_b + 1) % (B_OW * B_CN)) == 0);
        cnt_r_b += int'(ordering_read);
        cnt_s_b += int'(distance_shift);
      end
      ev_b = vld_b[ch]; ed_b = data_b[ch]; es_b = dis_b[dch];
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("a_valid", 64'(ov_a), 64'(ev_a));
      chk("a_data", od_a, ed_a);
      chk("a_dist", 64'(dr_a), 64'(es_a));
      chk("a_ord_chain", 64'(oc_a), 64'((cnt_r_a / A_OW) % A_CN));
      chk("a_dis_chain", 64'(dc_a), 64'(cnt_s_a % A_CN));
      chk("a_wrap", 64'(wrap_a), 64'(ew_a));
      chk("a_err", 64'(err_a), 64'(ee_a));
      chk("b_valid", 64'(ov_b), 64'(ev_b));
      chk("b_data", 64'(od_b), 64'(ed_b));
      chk("b_dist", 64'(dr_b), 64'(es_b));
      chk("b_ord_chain", 64'(oc_b), 64'((cnt_r_b / B_OW) % B_CN));
      chk("b_dis_chain", 64'(dc_b), 64'(cnt_s_b % B_CN));
      chk("b_wrap", 64'(wrap_b), 64'(ew_b));
      chk("b_err", 64'(err_b), 64'(ee_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_read();
    ordering_read = 1'b1;
    tick();
    ordering_read = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_clear = 1'b0; ordering_read = 1'b0; distance_shift = 1'b0;
    data_a[0] = 64'h11; data_a[1] = 64'h22; vld_a = '1;
    dis_a[0] = 32'd100; dis_a[1] = 32'd200;
    for (int c = 0; c < B_CN; c++) begin
      data_b[c] = 16'(16'hA0 + c);
      dis_b[c]  = 16'(1000 + c);
    end
    vld_b = '1;

    // reset held with live inputs
    repeat (3) tick();
    chk("lit_reset_data", od_a, 64'h0);
    chk("lit_reset_valid", 64'(ov_a), 64'h0);
    chk("lit_reset_dist", 64'(dr_a), 64'h0);
    reset = 1'b0;
    tick();
    chk("lit_first_data", od_a, 64'h11);
    chk("lit_first_chain", 64'(oc_a), 64'h0);
    chk("lit_first_b_data", 64'(od_b), 64'hA0);

    // chain sequencing over 8 reads
    for (int k = 1; k <= 8; k++) begin
      pulse_read();
      chk("lit_seq_a_chain", 64'(oc_a), 64'((k / 4) % 2));
      chk("lit_seq_a_wrap", 64'(wrap_a), 64'(k == 8));
      chk("lit_seq_b_chain", 64'(oc_b), 64'(k % 4));
      chk("lit_seq_b_wrap", 64'(wrap_b), 64'(k % 4 == 0));
      tick();
      chk("lit_seq_a_data", od_a, ((k / 4) % 2 == 1) ? 64'h22 : 64'h11);
      chk("lit_seq_b_data", 64'(od_b), 64'(16'hA0 + (k % 4)));
    end

    // distance toggling
    chk("lit_dist0", 64'(dr_a), 64'd100);
    for (int k = 1; k <= 3; k++) begin
      distance_shift = 1'b1;
      tick();
      distance_shift = 1'b0;
      tick();
      chk("lit_dist_a", 64'(dr_a), (k % 2 == 1) ? 64'd200 : 64'd100);
      chk("lit_dist_b", 64'(dr_b), 64'(1000 + k));
    end

    // rd_clear outranks a concurrent read
    repeat (5) pulse_read();
    chk("lit_pre_clear_chain", 64'(oc_a), 64'h1);
    rd_clear = 1'b1; ordering_read = 1'b1;
    tick();
    rd_clear = 1'b0; ordering_read = 1'b0;
    chk("lit_clear_chain", 64'(oc_a), 64'h0);
    chk("lit_clear_wrap", 64'(wrap_a), 64'h0);
    chk("lit_clear_dis", 64'(dc_a), 64'h0);
    chk("lit_clear_b_chain", 64'(oc_b), 64'h0);
    for (int k = 1; k <= 4; k++) begin
      pulse_read();
      chk("lit_post_clear_chain", 64'(oc_a), 64'(k == 4));
    end

    // error flag: read while chain 0 is not valid
    rd_clear = 1'b1; vld_a[0] = 1'b0;
    tick();
    rd_clear = 1'b0;
    tick();
    chk("lit_err_idle", 64'(err_a), 64'h0);
    pulse_read();
    chk("lit_err_set", 64'(err_a), 64'(ERR_EN));
    pulse_read();
    tick();
    chk("lit_err_sticky", 64'(err_a), 64'(ERR_EN));
    rd_clear = 1'b1;
    tick();
    rd_clear = 1'b0;
    chk("lit_err_clear", 64'(err_a), 64'h0);
    vld_a[0] = 1'b1;
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ordering_read  = 1'($urandom_range(0, 1));
      distance_shift = 1'($urandom_range(0, 1));
      rd_clear       = ($urandom_range(0, 31) == 0);
      reset          = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < A_CN; c++) begin
        data_a[c] = {$urandom(), $urandom()};
        dis_a[c]  = $urandom();
        vld_a[c]  = ($urandom_range(0, 7) != 0);
      end
      for (int c = 0; c < B_CN; c++) begin
        data_b[c] = 16'($urandom());
        dis_b[c]  = 16'($urandom());
        vld_b[c]  = ($urandom_range(0, 7) != 0);
      end
      tick();
    end
    ordering_read = 1'b0; distance_shift = 1'b0; rd_clear = 1'b0; reset = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
